// File: rtl/usr_seq_pkg.sv
// Shared encodings for the universal-shift-register sequencer: command ops,
// controller states and register select codes.
package usr_seq_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_TX   = 2'b01;
    localparam logic [1:0] OP_RX   = 2'b10;
    localparam logic [1:0] OP_TXRX = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Shift select for a direction bit: 0 = left, 1 = right.
    function automatic logic [1:0] shift_sel(input logic dir);
        shift_sel = dir ? SEL_SHR : SEL_SHL;
    endfunction

endpackage

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving one universal shift register (load / shift / respond).
// Optional macro USR_SEQ_CTRL_ROTATE_EN adds cmd_rot: TX recirculates SO into SI.
module usr_seq_ctrl
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef USR_SEQ_CTRL_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pi,
    output logic             usr_si,
    input  logic [WIDTH-1:0] usr_po,
    input  logic             usr_so,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         op_r;
    logic               dir_r;
    logic [WIDTH-1:0]   data_r;
    logic               accept_s;
`ifdef USR_SEQ_CTRL_ROTATE_EN
    logic               rot_r;
`endif

    assign accept_s = (state_r == ST_IDLE) && cmd_valid;

    // State, shift-length counter and latched command copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            op_r    <= 2'b00;
            dir_r   <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
`ifdef USR_SEQ_CTRL_ROTATE_EN
            rot_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r  <= cmd_len;
                op_r   <= cmd_op;
                dir_r  <= cmd_dir;
                data_r <= cmd_data;
`ifdef USR_SEQ_CTRL_ROTATE_EN
                rot_r  <= cmd_rot;
`endif
            end else if (state_r == ST_SHIFT) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state decode; RX skips the load cycle, zero length skips shifting.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_RX) begin
                        state_nxt_s = (cmd_len == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if ((op_r == OP_LOAD) || (cnt_r == CNT_ZERO)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // <= 1 rather than == 1 so a corrupted zero count cannot wrap.
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register and latched command.
    always_comb begin
        cmd_ready = 1'b0;
        usr_sel   = SEL_HOLD;
        usr_pi    = {WIDTH{1'b0}};
        usr_si    = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = {WIDTH{1'b0}};
        busy      = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                usr_sel = SEL_LOAD;
                usr_pi  = data_r;
            end
            ST_SHIFT: begin
                usr_sel   = shift_sel(dir_r);
                ser_valid = 1'b1;
                ser_out   = usr_so;
                if ((op_r == OP_RX) || (op_r == OP_TXRX)) begin
                    usr_si = ser_in;
                end else begin
`ifdef USR_SEQ_CTRL_ROTATE_EN
                    usr_si = rot_r ? usr_so : 1'b0;
`else
                    usr_si = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = usr_po;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule
